// File: rtl/alu_pkg.sv
// alu_pkg: shared carry-in mode codes and carry-chain sequencer state encodings.
package alu_pkg;

    localparam logic [1:0] MODE_ZERO      = 2'b00;
    localparam logic [1:0] MODE_ONE       = 2'b01;
    localparam logic [1:0] MODE_CHAIN     = 2'b10;
    localparam logic [1:0] MODE_CHAIN_INV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/cin_src_mux.sv
// cin_src_mux: 4:1 carry-in source select (zero, one, flag, inverted flag).
module cin_src_mux
    import alu_pkg::*;
(
    input  logic [1:0] mode,
    input  logic       cflag,
    output logic       cin
);

    always_comb begin
        cin = (mode == MODE_ZERO)  ? 1'b0 :
              (mode == MODE_ONE)   ? 1'b1 :
              (mode == MODE_CHAIN) ? cflag : ~cflag;
    end

endmodule

// File: rtl/carry_chain_ctrl.sv
// carry_chain_ctrl: sequences an NWORDS multi-word ALU operation one word per
// clock, chaining carries between words and holding the resulting carry flag.
module carry_chain_ctrl
    import alu_pkg::*;
#(
    parameter int NWORDS = 4,
    parameter int IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [1:0]      MODE,
    input  logic            COUT,
    input  logic            CLR_C,
    input  logic            SET_C,
    output logic            CIN,
    output logic [IDXW-1:0] IDX,
    output logic            BUSY,
    output logic            DONE,
    output logic            CFLAG
);

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [1:0]      mode_q, mode_d;
    logic            cflag_q, cflag_d;
    logic            carry_q, carry_d;
    logic            last;
    logic [1:0]      src_mode;
    logic            src_cin;

    assign last     = (idx_q == IDXW'(NWORDS - 1));
    // IDLE decodes the live MODE; the first RUN word uses the latched one.
    assign src_mode = (state_q == ST_IDLE) ? MODE : mode_q;

    cin_src_mux u_src (
        .mode  (src_mode),
        .cflag (cflag_q),
        .cin   (src_cin)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            mode_q  <= MODE_ZERO;
            cflag_q <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            cflag_q <= cflag_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        cflag_d = cflag_q;
        carry_d = carry_q;
        case (state_q)
            ST_IDLE: begin
                cflag_d = CLR_C ? 1'b0 : SET_C ? 1'b1 : cflag_q;
                if (START) begin
                    state_d = ST_RUN;
                    mode_d  = MODE;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                carry_d = COUT;
                idx_d   = last ? '0 : idx_q + IDXW'(1);
                cflag_d = last ? COUT : cflag_q;
                state_d = last ? ST_DONE : ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        CIN   = (state_q == ST_RUN)  ? ((idx_q == '0) ? src_cin : carry_q) :
                (state_q == ST_DONE) ? cflag_q : src_cin;
        IDX   = idx_q;
        BUSY  = (state_q == ST_RUN);
        DONE  = (state_q == ST_DONE);
        CFLAG = cflag_q;
    end

endmodule
